// File: rtl/bcd_gate_pkg.sv
// Shared types and constants for the BCD gate measurement controller.
package bcd_gate_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    HOLD
  } state_e;

  localparam int DIGIT_W   = 4;
  localparam int N_DECADES = 3;
  localparam int RES_W     = DIGIT_W * N_DECADES;

  localparam logic [RES_W-1:0] RES_SAT = 12'h999;

  // Result word layout is {hundreds, tens, ones}.
  function automatic logic [RES_W-1:0] pack_digits(
    input logic [DIGIT_W-1:0] hundreds,
    input logic [DIGIT_W-1:0] tens,
    input logic [DIGIT_W-1:0] ones
  );
    return {hundreds, tens, ones};
  endfunction

endpackage

// File: rtl/bcd_gate_controller_gate_timer.sv
// Gate window down-counter: loaded with the window length, decremented once per gate cycle.
module gate_timer #(
  parameter int GATE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [GATE_W-1:0] value,
  input  logic              dec,
  output logic              last,
  output logic              zero
);

  logic [GATE_W-1:0] cnt_q;
  logic [GATE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - GATE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == GATE_W'(1));
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bcd_gate_controller.sv
// Gate-window measurement controller for a three-decade BCD event counter:
// clears the counter, forwards events for N cycles, then holds the captured result.
module bcd_gate_controller
  import bcd_gate_pkg::*;
#(
  parameter int GATE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [GATE_W-1:0]  gate_len,
  input  logic               event_in,
  input  logic [DIGIT_W-1:0] cnt_ones,
  input  logic [DIGIT_W-1:0] cnt_tens,
  input  logic [DIGIT_W-1:0] cnt_hundreds,
  input  logic               cnt_carry,
  output logic               cnt_en,
  output logic               cnt_clr_n,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [RES_W-1:0]   res_bcd,
  output logic               res_ovf
);

  state_e             state_q, state_d;
  logic               ovf_q, ovf_d;
  logic               clr_n_q, clr_n_d;
  logic [RES_W-1:0]   res_bcd_q, res_bcd_d;
  logic               res_ovf_q, res_ovf_d;

  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_last;
  logic               tmr_zero;

  gate_timer #(
    .GATE_W (GATE_W)
  ) u_gate_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (gate_len),
    .dec   (tmr_dec),
    .last  (tmr_last),
    .zero  (tmr_zero)
  );

  // Counter enable is deliberately combinational so an event lands in the same cycle.
  assign cnt_en = event_in & (state_q == GATE);

  always_comb begin
    state_d   = state_q;
    ovf_d     = ovf_q;
    res_bcd_d = res_bcd_q;
    res_ovf_d = res_ovf_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = CLEAR;
          tmr_load = 1'b1;
          ovf_d    = 1'b0;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d = IDLE;
          ovf_d   = 1'b0;
        end else if (tmr_zero) begin
          state_d = SETTLE;
        end else begin
          state_d = GATE;
        end
      end
      GATE: begin
        tmr_dec = 1'b1;
        if (cnt_en && cnt_carry) begin
          ovf_d = 1'b1;
        end
        if (abort) begin
          state_d = IDLE;
          ovf_d   = 1'b0;
        end else if (tmr_last) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          ovf_d   = 1'b0;
        end else begin
          // Counter already shows the final gate-cycle increment here.
          state_d   = HOLD;
          res_ovf_d = ovf_q;
          res_bcd_d = ovf_q ? RES_SAT : pack_digits(cnt_hundreds, cnt_tens, cnt_ones);
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    clr_n_d = (state_d != CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ovf_q     <= 1'b0;
      clr_n_q   <= 1'b0;
      res_bcd_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      clr_n_q   <= clr_n_d;
      res_bcd_q <= res_bcd_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign cnt_clr_n = clr_n_q;
  assign busy      = (state_q == CLEAR) || (state_q == GATE) || (state_q == SETTLE);
  assign res_valid = (state_q == HOLD);
  assign res_bcd   = res_bcd_q;
  assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_bcd_gate_controller.sv
// Directed + randomized bench for bcd_gate_controller with a behavioural BCD counter and result model.
module tb_bcd_gate_controller;

  localparam int GATE_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [GATE_W-1:0] gate_len;
  logic              event_in;
  logic [3:0]        cnt_ones;
  logic [3:0]        cnt_tens;
  logic [3:0]        cnt_hundreds;
  logic              cnt_carry;
  logic              cnt_en;
  logic              cnt_clr_n;
  logic              busy;
  logic              res_valid;
  logic              res_ready;
  logic [11:0]       res_bcd;
  logic              res_ovf;

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [11:0] last_bcd = 12'h000;

  // Behavioural three-decade counter: plain integer 0..999 with wrap.
  int cnt_val = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge cnt_clr_n) begin
    if (!cnt_clr_n) begin
      cnt_val <= 0;
    end else if (cnt_en) begin
      cnt_val <= (cnt_val == 999) ? 0 : cnt_val + 1;
    end
  end

  assign cnt_ones     = 4'(cnt_val % 10);
  assign cnt_tens     = 4'((cnt_val / 10) % 10);
  assign cnt_hundreds = 4'(cnt_val / 100);
  assign cnt_carry    = (cnt_val == 999) && cnt_en;

  bcd_gate_controller #(
    .GATE_W (GATE_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .gate_len     (gate_len),
    .event_in     (event_in),
    .cnt_ones     (cnt_ones),
    .cnt_tens     (cnt_tens),
    .cnt_hundreds (cnt_hundreds),
    .cnt_carry    (cnt_carry),
    .cnt_en       (cnt_en),
    .cnt_clr_n    (cnt_clr_n),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_bcd      (res_bcd),
    .res_ovf      (res_ovf)
  );

  function automatic logic [11:0] to_bcd(input int c);
    return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One full measurement, entered and left on a falling clock edge.
  // mode: 0 = event every cycle, 1 = random events, 2 = no events.
  task automatic measure(input int n, input int mode, input int hold_cycles, input bit hs_start);
    int          ev_cnt;
    int          win_err;
    int          stab_err;
    int          lat;
    int          j;
    bit          got;
    bit          ev;
    bit          in_win;
    logic [11:0] exp_bcd;
    logic        exp_ovf;
    logic [11:0] held;
    ev_cnt  = 0;
    win_err = 0;
    got     = 1'b0;
    lat     = -1;
    gate_len = n[GATE_W-1:0];
    start    = 1'b1;
    for (int k = 1; k <= n + 12 && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      j = k - 1;
      if (res_valid === 1'b1) begin
        got = 1'b1;
        lat = j;
      end else begin
        if (busy !== (j <= n + 1)) win_err++;
        if (cnt_clr_n !== (j != 0)) win_err++;
        ev = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        event_in = ev;
        in_win = (j >= 1) && (j <= n);
        #1;
        if (cnt_en !== (ev && in_win)) win_err++;
        if (ev && in_win) ev_cnt++;
      end
    end
    event_in = 1'b0;
    exp_ovf = (ev_cnt > 999);
    exp_bcd = exp_ovf ? 12'h999 : to_bcd(ev_cnt);
    check($sformatf("latency_n%0d", n), 32'(lat), 32'(n + 2));
    check($sformatf("window_n%0d", n), 32'(win_err), 32'd0);
    check($sformatf("res_bcd_n%0d", n), 32'(res_bcd), 32'(exp_bcd));
    check($sformatf("res_ovf_n%0d", n), 32'(res_ovf), 32'(exp_ovf));
    held = res_bcd;
    if (hold_cycles > 0) begin
      stab_err = 0;
      for (int i = 0; i < hold_cycles; i++) begin
        start = i[0];
        abort = (i == 3);
        @(negedge clk);
        if (res_valid !== 1'b1 || busy !== 1'b0 || res_bcd !== held) stab_err++;
      end
      abort = 1'b0;
      check("hold_stable", 32'(stab_err), 32'd0);
    end
    res_ready = 1'b1;
    start     = hs_start;
    @(negedge clk);
    check($sformatf("handshake_valid_n%0d", n), 32'(res_valid), 32'd0);
    check($sformatf("handshake_idle_n%0d", n), 32'(busy), 32'd0);
    res_ready = 1'b0;
    start     = 1'b0;
    last_bcd  = exp_bcd;
  endtask

  initial begin
    int spur;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    gate_len  = '0;
    event_in  = 1'b1;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_bcd", 32'(res_bcd), 32'd0);
    check("rst_ovf", 32'(res_ovf), 32'd0);
    check("rst_clr_n", 32'(cnt_clr_n), 32'd0);
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_clr_n", 32'(cnt_clr_n), 32'd1);
    event_in = 1'b0;
    @(negedge clk);

    measure(10, 0, 0, 1'b0);
    measure(0, 0, 0, 1'b0);
    measure(1200, 0, 0, 1'b0);
    measure(999, 0, 0, 1'b0);
    measure(1000, 0, 0, 1'b0);
    measure(7, 1, 20, 1'b1);
    measure(4, 0, 0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      measure(int'($urandom_range(0, 40)), 1, 0, 1'b0);
    end

    // Abort in the 5th gate cycle.
    gate_len = 16'd20;
    start    = 1'b1;
    event_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(res_valid), 32'd0);
    check("abort_cnt_en", 32'(cnt_en), 32'd0);
    check("abort_res_kept", 32'(res_bcd), 32'(last_bcd));
    abort    = 1'b0;
    event_in = 1'b0;
    spur     = 0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) spur++;
    end
    check("abort_no_result", 32'(spur), 32'd0);
    measure(15, 1, 0, 1'b0);

    // Abort and start together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("abort_beats_start", 32'(busy), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    // Reset in the middle of a gate window.
    gate_len = 16'd50;
    start    = 1'b1;
    event_in = 1'b1;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(res_valid), 32'd0);
    check("midrst_clr_n", 32'(cnt_clr_n), 32'd0);
    check("midrst_cnt_en", 32'(cnt_en), 32'd0);
    check("midrst_bcd", 32'(res_bcd), 32'd0);
    reset    = 1'b0;
    event_in = 1'b0;
    @(negedge clk);
    check("midrst_rel_clr_n", 32'(cnt_clr_n), 32'd1);
    measure(12, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_gate_controller.md
# bcd_gate_controller

Measurement controller for the three-decade BCD event counter. It clears the counter, opens a programmable gate window of N clock cycles during which event strobes are forwarded to the counter's enable, and detects 999→000 rollover. After the gate closes it captures the BCD result and presents it on a valid/ready interface. It sits between a host or control FSM and the counter instance, and owns the counter's enable and reset.

## Interface
- GATE_W, 16, width of gate-length field and gate timer
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a measurement; honoured only in IDLE
- abort  in  1  cancel an in-flight measurement
- gate_len  in  GATE_W  gate window length in cycles, sampled with an accepted start
- event_in  in  1  synchronous event strobe, one count per high cycle
- cnt_ones, cnt_tens, cnt_hundreds  in  4 each  counter digit outputs
- cnt_carry  in  1  counter chained done: all digits 9 with enable high
- cnt_en  out  1  counter enable, combinational: event_in & (state==GATE)
- cnt_clr_n  out  1  registered, active-low, drives counter reset_n
- busy  out  1  high in CLEAR, GATE, SETTLE
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_bcd  out  12  {hundreds,tens,ones}
- res_ovf  out  1  counter overflowed during gate

## Operation
- States: IDLE, CLEAR, GATE, SETTLE, HOLD.
- IDLE:
  - start & !abort → CLEAR.
  - Load gate_len into the timer and clear the sticky ovf.
- CLEAR:
  - Lasts exactly 1 cycle, with cnt_clr_n=0.
  - gate_len==0 → SETTLE; otherwise → GATE.
- GATE:
  - Lasts exactly gate_len cycles. Timer decrements each cycle; on the cycle it reads 1 → SETTLE.
  - cnt_en & cnt_carry sets sticky ovf.
- SETTLE:
  - 1 cycle, so the final increment is visible.
  - At its closing edge, capture digits into res_bcd; if ovf, res_bcd=12'h999 (saturate) and res_ovf=1.
  - → HOLD.
- HOLD:
  - res_valid=1; res_bcd and res_ovf stable.
  - res_valid & res_ready → IDLE.
  - start is ignored, including in the handshake cycle.
- Abort:
  - abort in CLEAR, GATE or SETTLE → IDLE at the next edge. No result is produced, ovf is cleared, res_* are unchanged.
  - abort in IDLE or HOLD: no effect.
  - abort and start in the same IDLE cycle: abort wins.
- Events in CLEAR, SETTLE, HOLD and IDLE are not counted (cnt_en=0).
- Mid-operation reset: immediate return to IDLE with all reset values applied.

## Timing
- Reset values: state=IDLE, cnt_clr_n=0, busy=0, res_valid=0, res_bcd=0, res_ovf=0, cnt_en=0.
  - cnt_clr_n goes to 1 at the first clk edge after reset is released.
- start is sampled at edge t0. Subsequent edges:
  - CLEAR at t0.
  - GATE at t0+1.
  - SETTLE at t0+1+N.
  - HOLD (res_valid↑) at t0+N+2.
  - For N=0, HOLD at t0+2.
- res_valid falls at the edge where res_valid & res_ready is sampled. The earliest next accepted start is the following cycle.
- Width rules:
  - Timer is GATE_W bits; no wrap, since the load value is at most 2^GATE_W−1.
  - Counted events are at most N; more than 999 events always implies ovf=1.

## Structure
- Package bcd_gate_pkg holds:
  - state enum (IDLE, CLEAR, GATE, SETTLE, HOLD)
  - DIGIT_W=4, N_DECADES=3
  - RES_W=12, RES_SAT=12'h999
- Sub-module gate_timer (parameter GATE_W; ports load, value, dec, last) encapsulates the down-counter.
- FSM, ovf flag and result registers stay in the top level.

## Test plan
- Reset asserted mid-GATE → next cycle state IDLE, res_valid=0, cnt_clr_n=0, busy=0; after release, cnt_clr_n=1 next edge.
- gate_len=10, event_in held high → res_bcd=12'h010, res_ovf=0, res_valid rises at t0+12; res_ready=1 → IDLE one edge later.
- gate_len=1200, event_in high every cycle → res_ovf=1, res_bcd=12'h999.
- gate_len=0, event_in high → res_bcd=12'h000, res_valid at t0+2; event_in high during CLEAR/SETTLE not counted.
- gate_len=20, abort on 5th GATE cycle → IDLE next edge, no res_valid; new start gives a fresh cnt_clr_n low pulse and a correct count.
- HOLD with res_ready=0 for 20 cycles plus start pulses → start ignored, res_bcd stable; res_ready=1 → IDLE, and the next start is accepted.
